// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the shared-ALU / unified-memory RISC-V datapath.
// The state is registered; every datapath control is decoded from state plus mem_ready, zero and opcode.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_2_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_2_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    state_t cur_state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   opcode_legal;

    assign opcode_legal = (opcode == OP_R_TYPE) || (opcode == OP_I_TYPE) ||
                          (opcode == OP_LOAD)   || (opcode == OP_STORE)  ||
                          (opcode == OP_BRANCH) || (opcode == OP_JAL);

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R_TYPE: next_state = S_EXEC_R;
                    OP_I_TYPE: next_state = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE:  next_state = S_ADDR;
                    OP_BRANCH: next_state = S_BRANCH;
                    OP_JAL:    next_state = S_JUMP;
                    default:   next_state = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
            S_ADDR: begin
                next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) next_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (mem_ready) next_state = S_FETCH;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: next_state = S_FETCH;
            default: next_state = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (cur_state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut while the opcode is decoded.
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.illegal   = ~opcode_legal;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_WB_ALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_2_reg  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRC_B_REG;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_source  = PC_ALUOUT;
                ctrl.pc_write   = zero;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source  = PC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (arst) begin
            cur_state <= S_FETCH;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (instr_done) retired <= retired + CNT_W'(1);
        end
    end

    // Architectural side effects are blocked for as long as reset is held.
    assign pc_write   = ctrl.pc_write  & ~arst;
    assign ir_write   = ctrl.ir_write  & ~arst;
    assign reg_write  = ctrl.reg_write & ~arst;
    assign mem_write  = ctrl.mem_write & ~arst;
    assign instr_done = ctrl.instr_done & ~arst;
    assign illegal    = ctrl.illegal & ~arst;

    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_2_reg  = ctrl.mem_2_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed sequences plus a randomized
// instruction stream scored against a latency/effect model of each instruction class.
module tb_multicycle_control;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic        clk = 1'b0;
    logic        arst;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_2_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        instr_done, illegal;
    logic [31:0] retired;

    logic        pc_write_4, ir_write_4, iord_4, mem_read_4, mem_write_4, reg_write_4, mem_2_reg_4, alu_src_a_4;
    logic [1:0]  alu_src_b_4, alu_op_4, pc_source_4;
    logic [3:0]  state_4;
    logic        instr_done_4, illegal_4;
    logic [3:0]  retired_4;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .arst(arst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_2_reg(mem_2_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state(state), .instr_done(instr_done), .illegal(illegal), .retired(retired)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .arst(arst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write_4), .ir_write(ir_write_4), .iord(iord_4), .mem_read(mem_read_4),
        .mem_write(mem_write_4), .reg_write(reg_write_4), .mem_2_reg(mem_2_reg_4),
        .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4), .alu_op(alu_op_4), .pc_source(pc_source_4),
        .state(state_4), .instr_done(instr_done_4), .illegal(illegal_4), .retired(retired_4)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ill;
        int lat;
        bit rw;
        bit mw;
        bit pw;
        bit m2r;
        int ret;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   model_cnt = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

    // Directed run: seq holds the required state per cycle, one nibble per cycle from bit 0.
    task automatic dir_seq(input string nm, input logic [6:0] op, input int n,
                           input logic [15:0] rdy, input logic [15:0] z, input logic [63:0] seq);
        for (int k = 0; k < n; k++) begin
            logic [3:0] s;
            s = seq[4*k +: 4];
            opcode = op;
            mem_ready = rdy[k];
            zero = z[k];
            @(negedge clk);
            check({nm, "_state"},      32'(state),      32'(s));
            check({nm, "_mem_read"},   32'(mem_read),   32'(s == 0 || s == 5));
            check({nm, "_iord"},       32'(iord),       32'(s == 5 || s == 6));
            check({nm, "_mem_write"},  32'(mem_write),  32'(s == 6));
            check({nm, "_reg_write"},  32'(reg_write),  32'(s == 7 || s == 8));
            check({nm, "_mem_2_reg"},  32'(mem_2_reg),  32'(s == 8));
            check({nm, "_ir_write"},   32'(ir_write),   32'(s == 0 && rdy[k]));
            check({nm, "_pc_write"},   32'(pc_write),   32'((s == 0 && rdy[k]) || (s == 9 && z[k]) || s == 10));
            check({nm, "_pc_source"},  32'(pc_source),  (s == 9) ? 32'd1 : (s == 10) ? 32'd2 : 32'd0);
            check({nm, "_alu_op"},     32'(alu_op),     (s == 9) ? 32'd1 : (s == 2 || s == 3) ? 32'd2 : 32'd0);
            check({nm, "_instr_done"}, 32'(instr_done), 32'(s == 7 || s == 8 || s == 9 || s == 10 || (s == 6 && rdy[k])));
            check({nm, "_illegal"},    32'(illegal),    32'(s == 1 && !is_legal(op)));
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 jump, 6 illegal.
    task automatic run_instr(input int kind, input int fw, input int mw, input bit z);
        logic [6:0] op;
        int base;
        int len;
        int m0;
        bit ldst;
        exp_t e;
        case (kind)
            0: begin op = OP_R;      base = 4; end
            1: begin op = OP_I;      base = 4; end
            2: begin op = OP_LOAD;   base = 5; end
            3: begin op = OP_STORE;  base = 4; end
            4: begin op = OP_BRANCH; base = 3; end
            5: begin op = OP_JAL;    base = 3; end
            default: begin
                do op = 7'($urandom); while (is_legal(op));
                base = 2;
            end
        endcase
        ldst = (kind == 2) || (kind == 3);
        len = base + fw + (ldst ? mw : 0);
        m0 = fw + 3;
        e.ill = (kind == 6);
        e.lat = len;
        e.rw = (kind <= 2);
        e.mw = (kind == 3);
        e.pw = (kind == 4) ? z : (kind == 5);
        e.m2r = (kind == 2);
        e.ret = model_cnt;
        if (!e.ill) model_cnt++;
        sb.push_back(e);
        for (int k = 0; k < len; k++) begin
            opcode = (k <= fw) ? 7'($urandom) : op;
            if (k < fw) mem_ready = 1'b0;
            else if (k == fw) mem_ready = 1'b1;
            else if (ldst && k >= m0 && k < m0 + mw) mem_ready = 1'b0;
            else if (ldst && k == m0 + mw) mem_ready = 1'b1;
            else mem_ready = 1'($urandom);
            zero = (kind == 4 && k == fw + 2) ? z : 1'($urandom);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en || arst) begin
                cyc = 0;
            end else begin
                cyc++;
                if (instr_done || illegal) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_kind",      {30'd0, instr_done, illegal}, {30'd0, !e.ill, e.ill});
                        check("sb_latency",   32'(cyc),       32'(e.lat));
                        check("sb_reg_write", 32'(reg_write), 32'(e.rw));
                        check("sb_mem_write", 32'(mem_write), 32'(e.mw));
                        check("sb_pc_write",  32'(pc_write),  32'(e.pw));
                        check("sb_mem_2_reg", 32'(mem_2_reg), 32'(e.m2r));
                        check("sb_retired",   retired,        32'(e.ret));
                    end
                    cyc = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        arst = 1'b1;
        opcode = OP_R;
        zero = 1'b0;
        mem_ready = 1'b1;
        #2;
        @(negedge clk);
        check("rst_state",      32'(state),      32'd0);
        check("rst_retired",    retired,         32'd0);
        check("rst_retired4",   32'(retired_4),  32'd0);
        check("rst_instr_done", 32'(instr_done), 32'd0);
        check("rst_illegal",    32'(illegal),    32'd0);
        check("rst_mem_read",   32'(mem_read),   32'd1);
        check("rst_iord",       32'(iord),       32'd0);
        check("rst_pc_write",   32'(pc_write),   32'd0);
        check("rst_ir_write",   32'(ir_write),   32'd0);
        check("rst_reg_write",  32'(reg_write),  32'd0);
        check("rst_mem_write",  32'(mem_write),  32'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;

        dir_seq("rtype", OP_R, 4, 16'hFFFF, 16'h0000, 64'h7210);
        check("rtype_retired", retired, 32'd1);
        dir_seq("load_wait", OP_LOAD, 7, 16'h0067, 16'h0000, 64'h8555410);
        check("load_retired", retired, 32'd2);
        dir_seq("beq_taken", OP_BRANCH, 3, 16'hFFFF, 16'h0004, 64'h910);
        dir_seq("beq_not", OP_BRANCH, 3, 16'hFFFF, 16'h0000, 64'h910);
        check("branch_retired", retired, 32'd4);
        dir_seq("illegal", 7'b0000000, 2, 16'hFFFF, 16'h0000, 64'h10);
        check("illegal_retired", retired, 32'd4);
        dir_seq("jump", OP_JAL, 3, 16'hFFFF, 16'h0000, 64'hA10);
        check("jump_retired", retired, 32'd5);

        dir_seq("store", OP_STORE, 3, 16'hFFFF, 16'h0000, 64'h410);
        mem_ready = 1'b1;
        @(negedge clk);
        check("memwr_state",      32'(state),      32'd6);
        check("memwr_mem_write",  32'(mem_write),  32'd1);
        check("memwr_instr_done", 32'(instr_done), 32'd1);
        #1;
        arst = 1'b1;
        #1;
        check("arst_mid_mem_write",  32'(mem_write),  32'd0);
        check("arst_mid_state",      32'(state),      32'd0);
        check("arst_mid_retired",    retired,         32'd0);
        check("arst_mid_instr_done", 32'(instr_done), 32'd0);
        check("arst_mid_pc_write",   32'(pc_write),   32'd0);
        @(posedge clk);
        #1;
        check("arst_hold_retired", retired, 32'd0);
        arst = 1'b0;
        mon_en = 1'b1;
        model_cnt = 0;

        repeat (60) begin
            run_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end
        check("rand_retired_total", retired, 32'(model_cnt));
        check("rand_retired4_mod",  32'(retired_4), 32'(model_cnt % 16));

        mon_en = 1'b0;
        arst = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
        model_cnt = 0;
        mon_en = 1'b1;
        repeat (16) run_instr(5, $urandom_range(0, 1), 0, 1'b0);
        check("wrap_retired32", retired, 32'd16);
        check("wrap_retired4",  32'(retired_4), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
